// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares SDRAM channel ch0 between NCLI req/ack clients and issues keep-alive double reads.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, lowest index first.
module sdram_port_arbiter #(
  parameter int NCLI = 3,
  parameter int REFRESH_CYCLES = 1024,
  parameter logic [24:0] KA_ADDR = 25'h0000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCLI-1:0]   cli_req,
  input  logic [NCLI-1:0]   cli_we,
  input  logic [25*NCLI-1:0] cli_addr,
  input  logic [16*NCLI-1:0] cli_din,
  output logic [NCLI-1:0]   cli_ack,
  output logic [15:0]       cli_dout,
  output logic [24:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy
);
  localparam int KW = $clog2(REFRESH_CYCLES);
  localparam logic [KW-1:0] KA_MAX = KW'(REFRESH_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAITD = 2'd2, GAP = 2'd3;
  logic [1:0] state, owner, gnt_idx;
  logic owner_cli, cur_we, ka_phase, last_rd_valid, gnt_any, sel_we;
  logic [KW-1:0] ka_cnt;
  logic [24:1] last_rd_addr;
  logic [24:0] sel_addr;
  logic [15:0] sel_din;
  logic ka_pending, done, refreshed, ka_clear, grant;
  assign ka_pending = ka_cnt == KA_MAX;
  assign done = state == WAITD && !mem_busy;
  assign refreshed = done && owner_cli && !cur_we && last_rd_valid && last_rd_addr == mem_addr[24:1];
  assign ka_clear = refreshed || (done && !owner_cli && ka_phase);
  assign grant = state == IDLE && !mem_busy && !ka_pending && gnt_any;
`ifdef SDRAM_ARB_RR_EN
  logic [1:0] rr_ptr;
  logic [2*NCLI-1:0] rot;
  always_comb begin
    rot = {cli_req, cli_req} >> rr_ptr;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NCLI-1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'((int'(rr_ptr) + i) % NCLI);
      end
    end
  end
  // rr_ptr holds the index searched first, i.e. the one after the last client granted
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (grant) rr_ptr <= (gnt_idx == 2'(NCLI-1)) ? 2'd0 : gnt_idx + 2'd1;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NCLI-1; i >= 0; i--) begin
      if (cli_req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(i);
      end
    end
  end
`endif
  always_comb begin
    sel_addr = '0;
    sel_din = '0;
    sel_we = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_addr = cli_addr[25*i +: 25];
        sel_din = cli_din[16*i +: 16];
        sel_we = cli_we[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      owner_cli <= 1'b0;
      cur_we <= 1'b0;
      cli_ack <= '0;
      cli_dout <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      ka_cnt <= '0;
      ka_phase <= 1'b0;
      last_rd_addr <= '0;
      last_rd_valid <= 1'b0;
    end else begin
      cli_ack <= '0;
      ka_cnt <= ka_clear ? '0 : ka_pending ? ka_cnt : ka_cnt + KW'(1);
      case (state)
        IDLE: if (!mem_busy && (ka_pending || gnt_any)) begin
          state <= ISSUE;
          owner <= gnt_idx;
          owner_cli <= !ka_pending;
          cur_we <= !ka_pending && sel_we;
          mem_addr <= ka_pending ? KA_ADDR : sel_addr;
          mem_din <= ka_pending ? 16'h0000 : sel_din;
          mem_rd <= ka_pending || !sel_we;
          mem_wr <= !ka_pending && sel_we;
        end
        ISSUE: if (mem_busy) state <= WAITD;
        WAITD: if (!mem_busy) begin
          state <= GAP;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          last_rd_valid <= !cur_we;
          if (!cur_we) last_rd_addr <= mem_addr[24:1];
          if (!owner_cli) ka_phase <= !ka_phase;
          if (owner_cli) begin
            cli_dout <= mem_dout;
            cli_ack <= NCLI'(1) << owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed checks of arbitration, keep-alive, refresh tracking and reset abort.
module tb_sdram_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] cli_req = '0, cli_we = '0, cli_ack;
  logic [74:0] cli_addr = '0;
  logic [47:0] cli_din = '0;
  logic [15:0] cli_dout, mem_din, mem_dout;
  logic [24:0] mem_addr;
  logic mem_rd, mem_wr, mem_busy;
  int total = 0, bad = 0;

  sdram_port_arbiter #(.NCLI(3), .REFRESH_CYCLES(64), .KA_ADDR(25'h0)) dut (
    .clk(clk), .reset(reset), .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
    .cli_din(cli_din), .cli_ack(cli_ack), .cli_dout(cli_dout), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy));

  // controller model: starts on a strobe rising edge, busy for 3 cycles, data valid as busy falls
  logic m_busy = 1'b0, m_prev = 1'b0, hold_busy = 1'b0, mon_on = 1'b1;
  int m_cnt = 0, ka_seen = 0, strobe_err = 0;
  logic [7:0] m_a = '0;
  logic [15:0] m_dout = '0;
  logic [15:0] wr_m [0:255];
  logic [255:0] wr_v = '0;
  logic [24:0] log_q [$];
  assign mem_busy = m_busy | hold_busy;
  assign mem_dout = m_dout;

  function automatic logic [15:0] dflt(input logic [7:0] w);
    return (w == 8'h80) ? 16'hBEEF : 16'h1000 + {8'h00, w};
  endfunction

  always @(posedge clk) begin
    m_prev <= mem_rd | mem_wr;
    if ((mem_rd | mem_wr) && !m_prev && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt <= 3;
      m_a <= mem_addr[8:1];
      log_q.push_back(mem_addr);
      if (mem_rd && mem_addr == 25'h0) ka_seen <= ka_seen + 1;
      if (mem_wr) begin
        wr_m[mem_addr[8:1]] <= mem_din;
        wr_v[mem_addr[8:1]] <= 1'b1;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_dout <= wr_v[m_a] ? wr_m[m_a] : dflt(m_a);
      end
    end
  end

  always @(negedge clk)
    if (mon_on && m_busy && !(mem_rd | mem_wr)) strobe_err <= strobe_err + 1;

  // second instance with a short refresh period and a one-cycle-busy controller
  logic [2:0] ack2;
  logic [15:0] dout2, din2;
  logic [24:0] addr2, ka16_addr = '0;
  logic rd2, wr2, b2 = 1'b0, d2 = 1'b0, p2 = 1'b0, ack2_seen = 1'b0;
  int ka16_starts = 0;
  sdram_port_arbiter #(.NCLI(3), .REFRESH_CYCLES(16), .KA_ADDR(25'h0001235)) dut16 (
    .clk(clk), .reset(reset), .cli_req(3'b000), .cli_we(3'b000), .cli_addr(75'h0),
    .cli_din(48'h0), .cli_ack(ack2), .cli_dout(dout2), .mem_addr(addr2),
    .mem_rd(rd2), .mem_wr(wr2), .mem_din(din2), .mem_dout(16'h0000), .mem_busy(b2));

  always @(posedge clk) begin
    p2 <= rd2 | wr2;
    if (rd2 && !p2) begin
      ka16_starts <= ka16_starts + 1;
      ka16_addr <= addr2;
    end
    if ((rd2 | wr2) && !d2) begin
      if (!b2) b2 <= 1'b1;
      else begin
        b2 <= 1'b0;
        d2 <= 1'b1;
      end
    end
    if (!(rd2 | wr2)) d2 <= 1'b0;
    if (ack2 != 3'b000) ack2_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cli(input int c, input logic we, input logic [24:0] a, input logic [15:0] d);
    cli_we[c] = we;
    cli_addr[25*c +: 25] = a;
    cli_din[16*c +: 16] = d;
  endtask

  task automatic wait_ack(output logic [2:0] a);
    a = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cli_ack != 3'b000) begin
        a = cli_ack;
        break;
      end
    end
  endtask

  task automatic xact(input int c, input logic we, input logic [24:0] addr, input logic [15:0] d,
                      output logic [2:0] a, output logic [15:0] q);
    set_cli(c, we, addr, d);
    cli_req[c] = 1'b1;
    wait_ack(a);
    q = cli_dout;
    cli_req[c] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [2:0] a;
  logic [15:0] q;
  int lb, kb, hits;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {cli_ack, mem_rd, mem_wr, mem_addr, mem_din, cli_dout}, 64'h0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("ka16_early", ka16_starts, 0);
    repeat (15) @(negedge clk);
    check("ka16_reads", ka16_starts, 2);
    check("ka16_addr", ka16_addr, 25'h0001235);
    check("ka16_cnt", dut16.ka_cnt, 6);
    check("ka16_noack", ack2_seen, 0);

    do_reset();
    xact(1, 1'b0, 25'h000100, 16'h0, a, q);
    check("rd_ack", a, 3'b010);
    check("rd_dout", q, 16'hBEEF);
    @(negedge clk);
    check("ack_pulse", cli_ack, 3'b000);
    check("rd_low_after", mem_rd, 1'b0);

    do_reset();
    set_cli(0, 1'b0, 25'h40, 16'h0);
    set_cli(2, 1'b1, 25'hC4, 16'hCAFE);
    cli_req = 3'b101;
    wait_ack(a);
    check("cont_first", a, 3'b001);
    check("cont_first_dout", cli_dout, 16'h1020);
    cli_req[0] = 1'b0;
    wait_ack(a);
    check("cont_second", a, 3'b100);
    check("cont_wr_echo", cli_dout, 16'hCAFE);
    cli_req[2] = 1'b0;
    xact(1, 1'b0, 25'hC5, 16'h0, a, q);
    check("wr_readback", q, 16'hCAFE);
    check("addr_bit0", log_q[log_q.size()-1], 25'hC5);
    check("strobe_held", strobe_err, 0);

    do_reset();
    lb = log_q.size();
    kb = ka_seen;
    for (int i = 0; i < 100; i++) begin
      if (dut.ka_cnt == 6'd63) break;
      @(negedge clk);
    end
    set_cli(1, 1'b0, 25'h1FE, 16'h0);
    cli_req[1] = 1'b1;
    wait_ack(a);
    q = cli_dout;
    cli_req[1] = 1'b0;
    check("kavc_ack", a, 3'b010);
    check("kavc_dout", q, 16'h10FF);
    check("kavc_count", log_q.size() - lb, 3);
    if (log_q.size() >= lb + 3) begin
      check("kavc_order", {log_q[lb], log_q[lb+1], log_q[lb+2]}, {25'h0, 25'h0, 25'h1FE});
    end
    check("kavc_ka_reads", ka_seen - kb, 2);
    check("kavc_phase", dut.ka_phase, 1'b0);

    do_reset();
    kb = ka_seen;
    for (int r = 0; r < 8; r++) begin
      xact(0, 1'b0, 25'h10, 16'h0, a, q);
      xact(0, 1'b0, 25'h11, 16'h0, a, q);
      check("impl_dout", q, 16'h1008);
      repeat (20) @(negedge clk);
    end
    check("impl_no_ka", ka_seen - kb, 0);
    kb = ka_seen;
    for (int r = 0; r < 4; r++) begin
      xact(0, 1'b0, 25'h10, 16'h0, a, q);
      xact(0, 1'b1, 25'h12, 16'h5555, a, q);
      xact(0, 1'b0, 25'h11, 16'h0, a, q);
      xact(0, 1'b1, 25'h12, 16'h6666, a, q);
      repeat (20) @(negedge clk);
    end
    check("wr_breaks_refresh", (ka_seen - kb) > 0, 1'b1);

    do_reset();
    mon_on = 1'b0;
    set_cli(0, 1'b0, 25'h40, 16'h0);
    cli_req[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (dut.state == 2'd2) break;
      @(negedge clk);
    end
    check("rst_reached_waitd", dut.state, 2'd2);
    reset = 1'b1;
    hold_busy = 1'b1;
    cli_req = 3'b000;
    @(negedge clk);
    check("rst_rd_drop", mem_rd, 1'b0);
    check("rst_no_ack", cli_ack, 3'b000);
    reset = 1'b0;
    cli_req[0] = 1'b1;
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_rd | mem_wr | (cli_ack != 3'b000)) hits++;
    end
    check("busy_hold_no_strobe", hits, 0);
    hold_busy = 1'b0;
    wait_ack(a);
    q = cli_dout;
    cli_req = 3'b000;
    check("rereq_ack", a, 3'b001);
    check("rereq_dout", q, 16'h1020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 16-bit SDRAM controller channel (ch0) between NCLI clients using per-client req/ack handshakes.
- Translates level requests into the controller's edge-triggered rd/wr strobes and tracks its busy signal.
- The controller refreshes only when it sees a repeated read of the same 16-bit word. This block therefore also issues keep-alive double reads on a timer, so refresh still happens when clients never repeat a read.

Parameters:
NCLI, 3, number of client ports (2..4)
REFRESH_CYCLES, 1024, max clk cycles without a refresh-causing read before keep-alive is forced
KA_ADDR, 25'h0000000, byte address used for keep-alive reads (bit 0 ignored)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cli_req  in  NCLI  per-client request level; held until ack
cli_we  in  NCLI  per-client write (1) / read (0)
cli_addr  in  25*NCLI  per-client byte address, client i at [25*i+24:25*i]
cli_din  in  16*NCLI  per-client write data
cli_ack  out  NCLI  one-cycle completion pulse, one-hot
cli_dout  out  16  read data, valid when any cli_ack bit is high
mem_addr  out  25  to controller ch0_addr
mem_rd  out  1  to controller ch0_rd
mem_wr  out  1  to controller ch0_wr
mem_din  out  16  to controller ch0_din
mem_dout  in  16  from controller ch0_dout
mem_busy  in  1  from controller ch0_busy

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: cli_ack=0, cli_dout=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, state=IDLE, ka_cnt=0, ka_phase=0, last_rd_valid=0, rr pointer=0.
- All outputs are registered. mem_addr, mem_din, mem_rd and mem_wr stay stable from ISSUE entry until WAITD exit.
- State IDLE: acts only when mem_busy=0.
  - If ka_pending: latch KA_ADDR with we=0 and owner=none, then go to ISSUE.
  - Else if any cli_req: select a client per the arbitration rule, latch its addr/din/we and owner, then go to ISSUE.
  - Next cycle: mem_rd or mem_wr is high.
- State ISSUE: hold the strobe; on mem_busy=1, go to WAITD.
- State WAITD: when mem_busy=0:
  - drop mem_rd/mem_wr;
  - if owner is a client: cli_dout<=mem_dout (for writes, the echoed data) and pulse cli_ack[owner] for one cycle;
  - go to GAP.
- State GAP: one cycle with strobes low, so the controller's edge detector re-arms; then go to IDLE.
- Minimum client turnaround: 5 cycles plus controller latency. A client may hold req continuously and receive back-to-back grants, separated by GAP.
- Arbitration (default): fixed priority, lowest index wins. Requests arriving while a transaction is in flight wait; they are never dropped.
- Keep-alive timer:
  - ka_cnt increments every cycle and saturates at REFRESH_CYCLES-1; ka_pending = saturated.
  - ka_pending has priority over all clients.
  - The sequence is two consecutive reads of KA_ADDR (ka_phase 0 then 1); no client is granted between them.
  - ka_cnt clears when the second read completes.
- Refresh tracking:
  - last_rd_addr[24:1] and last_rd_valid are updated on every completed read; any completed write clears last_rd_valid.
  - A completed client read with last_rd_valid=1 and an equal word address clears ka_cnt (the controller refreshed).
- Byte addresses pass through unmodified; bit 0 is meaningful only to the controller.
- Simultaneous events:
  - ka_pending asserting in the same cycle as a client req: keep-alive wins.
  - A client dropping req before ack is illegal; the transaction still completes and the ack is still pulsed.
- Reset mid-transaction: all strobes drop immediately and no ack is issued. The aborted client must re-request. IDLE waits for mem_busy=0 before the first new issue.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at the index after the last granted client; the pointer updates only on client grants, not keep-alive grants.
- Undefined: fixed priority, lowest index wins; the pointer logic is absent.

Test Plan:
- Single read: c1 reads 25'h000100; the bench model returns 16'hBEEF -> mem_rd high until busy falls, then cli_ack=3'b010 for one cycle with cli_dout=16'hBEEF. mem_rd is low for at least 1 cycle before the next strobe.
- Contention: c0 and c2 req in the same cycle -> c0 is acked first, then c2. With SDRAM_ARB_RR_EN and all three held: grant order 0,1,2,0.
- Keep-alive: REFRESH_CYCLES=16, no client traffic -> after 16 cycles, two reads of KA_ADDR with no cli_ack, then ka_cnt=0.
- Implicit refresh: REFRESH_CYCLES=64; c0 reads 25'h10 then 25'h11 (same word), repeated every 20 cycles -> no keep-alive read is ever issued. Insert a c0 write between them -> keep-alive appears within 64 cycles.
- Keep-alive vs client: c1 req asserted in the cycle ka_pending rises -> both keep-alive reads complete before c1's grant, and c1 is acked afterwards.
- Reset in WAITD -> mem_rd=0 and cli_ack=0 the next cycle. With mem_busy held 1 for 3 cycles after reset, no strobe is issued until busy=0.
